// File: rtl/mux8_serializer_pkg.sv
// Shared constants for the 8:1 serializer: widths, FSM encoding and the
// select start/end indices that depend on the bit order.
package mux8_serializer_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    function automatic logic [SEL_W-1:0] sel_first(input logic lsb_first);
        return lsb_first ? 3'd0 : 3'd7;
    endfunction

    function automatic logic [SEL_W-1:0] sel_end(input logic lsb_first);
        return lsb_first ? 3'd7 : 3'd0;
    endfunction

endpackage

// File: rtl/mux8to1.sv
// Plain 8:1 bit multiplexer; the serializer drives its select lines.
module mux8to1
    import mux8_serializer_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [SEL_W-1:0]  sel,
    output logic              y
);

    assign y = data[sel];

endmodule

// File: rtl/mux8_serializer.sv
// Parallel-to-serial stage: registers an 8-bit word and walks the mux select
// across it, one bit per accepted downstream beat.
module mux8_serializer
    import mux8_serializer_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_data,
    output logic [SEL_W-1:0]  ser_sel,
    output logic              ser_last,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt
);

    logic [0:0]        state;
    logic [DATA_W-1:0] data_q;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  sel_start;
    logic [SEL_W-1:0]  sel_stop;
    logic [SEL_W-1:0]  sel_next;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;
    logic              beat;

    assign sel_start = sel_first(LSB_FIRST);
    assign sel_stop  = sel_end(LSB_FIRST);
    // Only used on non-final beats, so the counter never wraps by arithmetic.
    assign sel_next  = LSB_FIRST ? sel_q + SEL_W'(1) : sel_q - SEL_W'(1);

    assign ser_valid = (state == ST_SHIFT);
    assign busy      = (state == ST_SHIFT);
    assign ser_sel   = sel_q;
    assign ser_last  = ser_valid && (sel_q == sel_stop);
    // Opening in_ready on the final beat lets the next word follow with no gap.
    assign in_ready  = (state == ST_IDLE) || (ser_last && ser_ready);
    assign accept    = in_valid && in_ready;
    assign beat      = ser_valid && ser_ready;
    assign word_cnt  = cnt_q;

    mux8to1 u_mux (
        .data (data_q),
        .sel  (sel_q),
        .y    (ser_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            data_q <= '0;
            sel_q  <= sel_start;
            cnt_q  <= '0;
        end else begin
            if (beat) begin
                if (ser_last) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    state <= ST_IDLE;
                end else begin
                    sel_q <= sel_next;
                end
            end
            // A new word overrides the return to IDLE on the final beat.
            if (accept) begin
                data_q <= in_data;
                sel_q  <= sel_start;
                state  <= ST_SHIFT;
            end
        end
    end

endmodule

// File: tb/tb_mux8_serializer.sv
// Scoreboard bench: three serializer instances (LSB-first, MSB-first, 2-bit
// counter) share one stimulus stream; a negedge monitor checks every beat.
module tb_mux8_serializer;

    typedef struct packed {
        logic [2:0] lsel;
        logic       ldat;
        logic       llast;
        logic [2:0] msel;
        logic       mdat;
        logic       mlast;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        ser_ready;

    logic        a_in_ready, a_valid, a_data, a_last, a_busy;
    logic [2:0]  a_sel;
    logic [15:0] a_cnt;
    logic        b_in_ready, b_valid, b_data, b_last, b_busy;
    logic [2:0]  b_sel;
    logic [15:0] b_cnt;
    logic        c_in_ready, c_valid, c_data, c_last, c_busy;
    logic [2:0]  c_sel;
    logic [1:0]  c_cnt;

    beat_t exp_q[$];
    beat_t mon_e;
    bit    mon_v;
    bit    mon_en;
    int    n_checks;
    int    n_pass;
    int    waits;

    mux8_serializer #(.LSB_FIRST(1'b1), .CNT_W(16)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .ser_valid(a_valid), .ser_ready(ser_ready),
        .ser_data(a_data), .ser_sel(a_sel), .ser_last(a_last),
        .busy(a_busy), .word_cnt(a_cnt)
    );

    mux8_serializer #(.LSB_FIRST(1'b0), .CNT_W(16)) u_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .ser_valid(b_valid), .ser_ready(ser_ready),
        .ser_data(b_data), .ser_sel(b_sel), .ser_last(b_last),
        .busy(b_busy), .word_cnt(b_cnt)
    );

    mux8_serializer #(.LSB_FIRST(1'b1), .CNT_W(2)) u_cnt2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .ser_valid(c_valid), .ser_ready(ser_ready),
        .ser_data(c_data), .ser_sel(c_sel), .ser_last(c_last),
        .busy(c_busy), .word_cnt(c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Offer a word, wait for in_ready, then queue the eight beats it must produce.
    task automatic applyStimulus(input logic [7:0] w, output int n_wait);
        n_wait = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        #1;
        while (!a_in_ready && n_wait < 100) begin
            @(negedge clk);
            #1;
            n_wait++;
        end
        if (!a_in_ready) begin
            checkOutput("accept_timeout", int'(a_in_ready), 1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back('{lsel: 3'(i), ldat: w[i], llast: (i == 7),
                                  msel: 3'(7 - i), mdat: w[7 - i], mlast: (i == 7)});
            end
            in_valid = 1'b0;
            in_data  = ~w;
        end
    endtask

    task automatic drainWords();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            #3;
            n++;
        end
        checkOutput("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag, input int cnt16, input int cnt2);
        checkOutput({tag, "_lsb_valid"}, int'(a_valid), 0);
        checkOutput({tag, "_msb_valid"}, int'(b_valid), 0);
        checkOutput({tag, "_lsb_busy"}, int'(a_busy), 0);
        checkOutput({tag, "_lsb_last"}, int'(a_last), 0);
        checkOutput({tag, "_lsb_in_ready"}, int'(a_in_ready), 1);
        checkOutput({tag, "_msb_in_ready"}, int'(b_in_ready), 1);
        checkOutput({tag, "_lsb_cnt"}, int'(a_cnt), cnt16);
        checkOutput({tag, "_msb_cnt"}, int'(b_cnt), cnt16);
        checkOutput({tag, "_cnt2"}, int'(c_cnt), cnt2);
    endtask

    // Monitor: queue occupancy defines whether a beat is expected this cycle.
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            mon_v = (exp_q.size() != 0);
            mon_e = mon_v ? exp_q[0] : '0;
            checkOutput("lsb_valid", int'(a_valid), int'(mon_v));
            checkOutput("msb_valid", int'(b_valid), int'(mon_v));
            checkOutput("cnt2_valid", int'(c_valid), int'(mon_v));
            checkOutput("lsb_busy", int'(a_busy), int'(mon_v));
            checkOutput("msb_busy", int'(b_busy), int'(mon_v));
            if (mon_v) begin
                checkOutput("lsb_sel", int'(a_sel), int'(mon_e.lsel));
                checkOutput("lsb_data", int'(a_data), int'(mon_e.ldat));
                checkOutput("lsb_last", int'(a_last), int'(mon_e.llast));
                checkOutput("msb_sel", int'(b_sel), int'(mon_e.msel));
                checkOutput("msb_data", int'(b_data), int'(mon_e.mdat));
                checkOutput("msb_last", int'(b_last), int'(mon_e.mlast));
                checkOutput("cnt2_sel", int'(c_sel), int'(mon_e.lsel));
                checkOutput("cnt2_data", int'(c_data), int'(mon_e.ldat));
                if (ser_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got %0d queued beats, expected 0", exp_q.size());
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        mon_en    = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        ser_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkIdle("reset", 0, 0);
        checkOutput("reset_lsb_sel", int'(a_sel), 0);
        checkOutput("reset_msb_sel", int'(b_sel), 7);
        mon_en = 1'b1;

        // A5 both ways: LSB 1,0,1,0,0,1,0,1 over sel 0..7, MSB over sel 7..0.
        applyStimulus(8'hA5, waits);
        drainWords();
        checkIdle("a5", 1, 1);

        // 3C stalled three cycles while sel 2 (bit value 1) is presented.
        applyStimulus(8'h3C, waits);
        repeat (2) @(negedge clk);
        @(negedge clk);
        ser_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            #3;
            checkOutput("stall_sel", int'(a_sel), 2);
            checkOutput("stall_data", int'(a_data), 1);
            checkOutput("stall_valid", int'(a_valid), 1);
        end
        @(negedge clk);
        ser_ready = 1'b1;
        drainWords();
        checkIdle("3c", 2, 2);

        // FF then 00 back to back: second word accepted on the seventh wait.
        applyStimulus(8'hFF, waits);
        checkOutput("b2b_first_wait", waits, 0);
        applyStimulus(8'h00, waits);
        checkOutput("b2b_second_wait", waits, 7);
        checkOutput("b2b_mid_cnt", int'(a_cnt), 3);
        checkOutput("b2b_mid_cnt2", int'(c_cnt), 3);
        drainWords();
        checkIdle("b2b", 4, 0);

        // Reset while sel 4 of 0F is on the wire; the counter returns to zero.
        applyStimulus(8'h0F, waits);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #3;
        checkOutput("pre_reset_sel", int'(a_sel), 4);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        checkIdle("midrst", 0, 0);
        @(negedge clk);
        #3;
        checkIdle("midrst_next", 0, 0);

        applyStimulus(8'h81, waits);
        #1;
        checkOutput("post_rst_first_sel", int'(a_sel), 0);
        checkOutput("post_rst_first_data", int'(a_data), 1);
        drainWords();
        checkIdle("w81", 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
